// File: rtl/rc_filter_pkg.sv
// Shared types, constants and arithmetic helpers for the RC filter bank.
package rc_filter_pkg;

    localparam int unsigned DefNCh = 4;
    localparam int unsigned DefW   = 16;
    localparam int unsigned DefCW  = 16;
    localparam int unsigned DefCF  = 15;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    // Half an LSB of the fractional alpha scale; adding it before the shift rounds half up.
    function automatic logic signed [63:0] rnd_const(input int unsigned cf);
        return (cf == 0) ? 64'sd0 : (64'sd1 <<< (cf - 1));
    endfunction

    // Clamp a wide signed value into the w-bit signed range.
    function automatic logic signed [63:0] sat_w(input logic signed [63:0] v,
                                                 input int unsigned w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/rc_filter_bank_if.sv
// Sample-vector handshake and filtered-output bus of the RC filter bank.
interface rc_filter_bank_if
    import rc_filter_pkg::*;
#(
    parameter int unsigned N_CH = DefNCh,
    parameter int unsigned W    = DefW,
    parameter int unsigned CW   = DefCW
);

    logic                in_valid;
    logic                in_ready;
    logic [N_CH*W-1:0]   v_in;
    logic [CW-1:0]       alpha;
    logic                hold;
    logic                clear;
    logic [N_CH*W-1:0]   v_out;
    logic                out_valid;

    modport master (
        output in_valid, v_in, alpha, hold, clear,
        input  in_ready, v_out, out_valid
    );

    modport slave (
        input  in_valid, v_in, alpha, hold, clear,
        output in_ready, v_out, out_valid
    );

endinterface

// File: rtl/rc_filter_step.sv
// Single-channel RC update: y_next = sat(y + round((x - y) * alpha / 2^CF)).
module rc_filter_step
    import rc_filter_pkg::*;
#(
    parameter int unsigned W  = DefW,
    parameter int unsigned CW = DefCW,
    parameter int unsigned CF = DefCF
) (
    input  logic signed [W-1:0] x_i,
    input  logic signed [W-1:0] y_i,
    input  logic [CW-1:0]       alpha_i,
    output logic signed [W-1:0] y_next_o
);

    // Wide enough for (x - y) * alpha plus the rounding offset without overflow.
    localparam int unsigned PW = W + CW + 2;

    logic signed [PW-1:0] x_e;
    logic signed [PW-1:0] y_e;
    logic signed [PW-1:0] a_e;
    logic signed [PW-1:0] diff;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] prod_rnd;
    logic signed [PW-1:0] delta;
    logic signed [63:0]   sum;

    // Difference, scale by alpha (zero-extended), round, shift and saturate.
    always_comb begin
        x_e      = PW'(x_i);
        y_e      = PW'(y_i);
        a_e      = PW'(alpha_i);
        diff     = x_e - y_e;
        prod     = diff * a_e;
        prod_rnd = prod + PW'(rnd_const(CF));
        delta    = prod_rnd >>> CF;
        sum      = 64'(delta) + 64'(y_i);
        y_next_o = W'(sat_w(sum, W));
    end

endmodule

// File: rtl/rc_filter_bank.sv
// N-channel first-order RC low-pass bank sharing one multiplier across channels.
module rc_filter_bank
    import rc_filter_pkg::*;
#(
    parameter int unsigned N_CH = DefNCh,
    parameter int unsigned W    = DefW,
    parameter int unsigned CW   = DefCW,
    parameter int unsigned CF   = DefCF
) (
    input  logic            clk,
    input  logic            rst,
    rc_filter_bank_if.slave bus
);

    localparam int unsigned CntW = (N_CH > 1) ? $clog2(N_CH) : 1;

    state_e                    state_q, state_d;
    logic [CntW-1:0]           cnt_q, cnt_d;
    logic [N_CH-1:0][W-1:0]    x_q, x_d;
    logic [CW-1:0]             alpha_q, alpha_d;
    logic                      hold_q, hold_d;
    logic [N_CH-1:0][W-1:0]    y_q, y_d;
    logic [N_CH-1:0][W-1:0]    v_out_q, v_out_d;
    logic                      out_valid_q, out_valid_d;
    logic                      in_ready;
    logic signed [W-1:0]       x_sel;
    logic signed [W-1:0]       y_sel;
    logic signed [W-1:0]       y_next;

    // Channel selected by the counter feeds the shared datapath.
    always_comb begin
        x_sel = x_q[cnt_q];
        y_sel = y_q[cnt_q];
    end

    rc_filter_step #(
        .W  (W),
        .CW (CW),
        .CF (CF)
    ) u_step (
        .x_i      (x_sel),
        .y_i      (y_sel),
        .alpha_i  (alpha_q),
        .y_next_o (y_next)
    );

    // Next-state: accept/clear in idle, one channel per cycle in calc, publish on the last one.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        x_d         = x_q;
        alpha_d     = alpha_q;
        hold_d      = hold_q;
        y_d         = y_q;
        v_out_d     = v_out_q;
        out_valid_d = 1'b0;
        in_ready    = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    x_d     = bus.v_in;
                    alpha_d = bus.alpha;
                    hold_d  = bus.hold;
                    cnt_d   = '0;
                    state_d = StCalc;
                end else if (bus.clear) begin
                    y_d = '0;
                end
            end
            StCalc: begin
                if (!hold_q) begin
                    y_d[cnt_q] = y_next;
                end
                if (cnt_q == CntW'(N_CH - 1)) begin
                    // Load the whole vector at once so DONE presents a complete update.
                    v_out_d     = y_d;
                    out_valid_d = 1'b1;
                    state_d     = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; reset discards any vector in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            x_q         <= '0;
            alpha_q     <= '0;
            hold_q      <= 1'b0;
            y_q         <= '0;
            v_out_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            alpha_q     <= alpha_d;
            hold_q      <= hold_d;
            y_q         <= y_d;
            v_out_q     <= v_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.v_out     = v_out_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_rc_filter_bank.sv
// Directed bench for rc_filter_bank: vector table plus handshake and reset sequences.
module tb_rc_filter_bank;

    localparam int unsigned NCh = 4;
    localparam int unsigned W   = 16;
    localparam int unsigned CW  = 16;
    localparam int unsigned CF  = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    rc_filter_bank_if #(.N_CH(NCh), .W(W), .CW(CW)) bus ();

    rc_filter_bank #(
        .N_CH (NCh),
        .W    (W),
        .CW   (CW),
        .CF   (CF)
    ) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    typedef struct {
        logic [63:0] v_in;
        logic [15:0] alpha;
        logic        hold;
        logic        clr;
        logic [63:0] exp;
    } vec_t;

    vec_t        tbl[10];
    int          checks   = 0;
    int          failures = 0;
    logic [63:0] model_out;

    function automatic logic [63:0] p4(input int c3, input int c2, input int c1, input int c0);
        return {16'(c3), 16'(c2), 16'(c1), 16'(c0)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pulse_clear();
        bus.clear = 1'b1;
        @(posedge clk);
        #1;
        bus.clear = 1'b0;
    endtask

    // Send one vector from IDLE and check latency, output stability, value and pulse width.
    task automatic run_vec(input string name, input logic [63:0] v, input logic [15:0] a,
                           input logic h, input logic clr_same, input logic [63:0] exp,
                           input logic [63:0] prev);
        int   cyc;
        logic stable;
        check({name, ".ready"}, 64'(bus.in_ready), 64'd1);
        bus.v_in     = v;
        bus.alpha    = a;
        bus.hold     = h;
        bus.clear    = clr_same;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.clear    = 1'b0;
        // Scramble inputs while the vector is being processed.
        bus.v_in     = ~v;
        bus.alpha    = ~a;
        bus.hold     = ~h;
        cyc    = 1;
        stable = 1'b1;
        while (bus.out_valid !== 1'b1 && cyc <= 20) begin
            if (bus.v_out !== prev) stable = 1'b0;
            @(posedge clk);
            #1;
            cyc++;
        end
        check({name, ".lat"}, 64'(cyc), 64'(NCh + 1));
        check({name, ".stable"}, 64'(stable), 64'd1);
        check({name, ".vout"}, bus.v_out, exp);
        @(posedge clk);
        #1;
        check({name, ".pulse"}, 64'(bus.out_valid), 64'd0);
        check({name, ".ready2"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        int          acc;
        int          low;
        int          nout;
        int          ovc;
        logic [63:0] outs[2];

        bus.in_valid = 1'b0;
        bus.v_in     = '0;
        bus.alpha    = '0;
        bus.hold     = 1'b0;
        bus.clear    = 1'b0;
        model_out    = '0;

        tbl[0] = '{p4(1000, 1000, 1000, 1000), 16'h4000, 1'b0, 1'b0, p4(500, 500, 500, 500)};
        tbl[1] = '{p4(1000, 1000, 1000, 1000), 16'h4000, 1'b0, 1'b0, p4(750, 750, 750, 750)};
        tbl[2] = '{p4(1000, 1000, 1000, 1000), 16'h4000, 1'b0, 1'b0, p4(875, 875, 875, 875)};
        tbl[3] = '{p4(5000, 5000, 5000, 5000), 16'h4000, 1'b1, 1'b0, p4(875, 875, 875, 875)};
        tbl[4] = '{p4(0, 1000, 3, -1000), 16'h4000, 1'b0, 1'b1, p4(0, 500, 2, -500)};
        tbl[5] = '{p4(100, 32767, 32767, 32767), 16'hFFFF, 1'b0, 1'b1,
                   p4(200, 32767, 32767, 32767)};
        tbl[6] = '{p4(-32768, -32768, -32768, -32768), 16'hFFFF, 1'b0, 1'b0,
                   p4(-32768, -32768, -32768, -32768)};
        tbl[7] = '{p4(1234, 1234, 1234, 1234), 16'h0000, 1'b0, 1'b0,
                   p4(-32768, -32768, -32768, -32768)};
        tbl[8] = '{p4(32767, 0, -5, 777), 16'h8000, 1'b0, 1'b0, p4(32767, 0, -5, 777)};
        tbl[9] = '{p4(1000, 1000, 1000, 1000), 16'h4000, 1'b0, 1'b1, p4(500, 500, 500, 500)};

        // Reset values while reset is held.
        #12;
        check("rst.vout", bus.v_out, 64'd0);
        check("rst.ovalid", 64'(bus.out_valid), 64'd0);
        check("rst.ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            if (tbl[i].clr) pulse_clear();
            run_vec($sformatf("row%0d", i), tbl[i].v_in, tbl[i].alpha, tbl[i].hold, 1'b0,
                    tbl[i].exp, model_out);
            model_out = tbl[i].exp;
        end

        // Clear arriving with an accept is ignored: 500 -> 1000, not 750.
        run_vec("clr_acc", p4(1500, 1500, 1500, 1500), 16'h4000, 1'b0, 1'b1,
                p4(1000, 1000, 1000, 1000), model_out);
        model_out = p4(1000, 1000, 1000, 1000);

        // in_valid held high: one accept per NCh+2 cycles, inputs ignored during CALC.
        pulse_clear();
        bus.v_in     = p4(1000, 1000, 1000, 1000);
        bus.alpha    = 16'h4000;
        bus.hold     = 1'b0;
        bus.in_valid = 1'b1;
        acc  = 0;
        low  = 0;
        nout = 0;
        outs[0] = '0;
        outs[1] = '0;
        for (int i = 0; i < 12; i++) begin
            if (bus.in_ready === 1'b1) acc++;
            else low++;
            if (bus.out_valid === 1'b1 && nout < 2) begin
                outs[nout] = bus.v_out;
                nout++;
            end
            if (i == 2) bus.v_in = p4(8000, 8000, 8000, 8000);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        check("hs.accepts", 64'(acc), 64'd2);
        check("hs.busy", 64'(low), 64'd10);
        check("hs.nout", 64'(nout), 64'd2);
        check("hs.out0", outs[0], p4(500, 500, 500, 500));
        check("hs.out1", outs[1], p4(4250, 4250, 4250, 4250));

        // Reset in the middle of CALC.
        bus.v_in     = p4(2000, 2000, 2000, 2000);
        bus.alpha    = 16'h4000;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid.vout", bus.v_out, 64'd0);
        check("mid.ready", 64'(bus.in_ready), 64'd1);
        check("mid.ovalid", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ovc = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid === 1'b1) ovc++;
        end
        check("mid.nopulse", 64'(ovc), 64'd0);
        model_out = '0;
        run_vec("post_rst", p4(1000, 1000, 1000, 1000), 16'h4000, 1'b0, 1'b0,
                p4(500, 500, 500, 500), model_out);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rc_filter_bank.md
Name: rc_filter_bank

Overview:
- Parametrised multi-channel first-order RC low-pass model in signed fixed point. Generalises the single-channel RC circuit model to N channels.
- Per-sample update: y <= y + alpha*(x - y), with alpha = dt/tau supplied at run time.
- One shared multiplier, time-multiplexed across channels by a small FSM, behind a valid/ready input handshake.
- Sits between stimulus/DAC models and downstream analog-behaviour blocks in emulation testbenches.

Parameters:
- N_CH, 4, number of channels (>=1).
- W, 16, signed sample width for v_in and v_out.
- CW, 16, unsigned coefficient width of alpha.
- CF, 15, fractional bits of alpha (alpha = code/2^CF; CF <= CW).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  new sample vector present.
- in_ready  out  1  block can accept a vector.
- v_in  in  N_CH*W  packed signed inputs; channel k at [k*W +: W].
- alpha  in  CW  shared coefficient, sampled on accept.
- hold  in  1  sampled on accept; 1 = state frozen for this sample.
- clear  in  1  zero all channel state; honoured only in IDLE.
- v_out  out  N_CH*W  packed filtered outputs, registered.
- out_valid  out  1  one-cycle pulse when v_out is updated.

Behaviour:
Reset (rst=0, async):
- State array = 0, v_out = 0, out_valid = 0, in_ready = 1, FSM = IDLE, channel counter = 0.

FSM states: IDLE, CALC, DONE.
- IDLE: in_ready=1.
  - in_valid=1: latch v_in, alpha, hold; counter=0; go to CALC.
  - Else if clear=1: zero the state array; v_out unchanged; no out_valid.
  - in_valid and clear both high: accept wins; clear is ignored that cycle.
- CALC: in_ready=0; update channel `counter` once per cycle; counter++.
  - After channel N_CH-1 is updated, go to DONE.
- DONE: copy the state array to v_out; out_valid=1 for this cycle only; go to IDLE.
- in_valid while in_ready=0 is ignored; the source must hold until accepted.

Latency:
- Accept at cycle 0; channel k written at cycle k+1.
- out_valid is high at cycle N_CH+1.
- Next accept possible at cycle N_CH+2.
- Throughput: one vector per N_CH+2 cycles.

Arithmetic, per channel:
- diff = x - y, W+1 bits signed.
- prod = diff * alpha, with alpha zero-extended; W+CW+2 bits signed.
- delta = (prod + 2^(CF-1)) >>> CF, arithmetic shift (round half up).
- y_next = sat_W(y + delta): saturate to [-2^(W-1), 2^(W-1)-1]; no wrap-around ever.
- alpha=0 means state unchanged.
- Codes with alpha > 2^CF are legal (overshoot) and still saturate.

Modes:
- hold=1: CALC still runs the full N_CH cycles but writes are suppressed; out_valid still pulses with unchanged v_out.

Reset mid-CALC:
- All state is lost and v_out returns to 0.
- No out_valid is issued for the aborted vector.

Output stability:
- v_out changes only in DONE. It is never partially updated.

Decomposition:
- Package rc_filter_pkg holds:
  - FSM state enum.
  - Saturation function.
  - Rounding constant.
  - Default parameter constants.
- Sub-module rc_filter_step: combinational single-channel datapath (x, y, alpha -> y_next), with parameters W, CW, CF.
  - Instantiated once in the top and unit-testable alone.

Test Plan:
1. Step response. N_CH=4, alpha=0x4000 (0.5), all v_in=1000, three accepts -> v_out channels 500, then 750, then 875; out_valid pulses exactly at cycle 5 after each accept.
2. Negative and rounding. Channel 0 v_in=-1000, alpha=0x4000 from y=0 -> -500; channel 1 v_in=3, alpha=0x4000 -> 2 (1.5 rounds up).
3. Saturation. alpha=0xFFFF (~2.0), v_in=32767 from y=0 -> 32767 (no wrap); then v_in=-32768 -> -32768.
4. Hold and clear.
   - hold=1 with v_in=5000 -> v_out unchanged, out_valid still pulses.
   - clear=1 in IDLE, then v_in=1000, alpha=0x4000 -> 500.
   - in_valid and clear same cycle -> accept, state not cleared.
5. Handshake. in_valid held high continuously -> in_ready low for 5 cycles after each accept; exactly one accept per 6 cycles; input changes during CALC have no effect.
6. Reset mid-CALC. Assert rst at cycle 2 after accept -> v_out=0 and in_ready=1 immediately (async); no out_valid; next vector 1000 with alpha 0.5 -> 500.
